// File: rtl/cnt_ctrl_pkg.sv
// Shared types for the counter command controller: FSM states and response status codes.
package cnt_ctrl_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_e;

  typedef enum logic [STATUS_W-1:0] {
    ST_OK       = 2'd0,
    ST_TIMEOUT  = 2'd1,
    ST_ABORT    = 2'd2,
    ST_LOAD_ERR = 2'd3
  } status_e;

endpackage

// File: rtl/counter_ctrl.sv
// Command-driven controller for the loadable up/down counter: load, run to terminal count, report.
// Optional load read-back check enabled by defining CNT_CTRL_LOAD_CHECK_EN.
module counter_ctrl
  import cnt_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DATA_W-1:0]   cmd_value,
  input  logic                cmd_dir,
  input  logic                cmd_abort,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [STATUS_W-1:0] rsp_status,
  output logic [CYC_W-1:0]    rsp_cycles,
  output logic                cnt_load,
  output logic                cnt_enable,
  output logic                cnt_up_down,
  output logic [DATA_W-1:0]   cnt_data,
  input  logic [DATA_W-1:0]   cnt_count_in,
  input  logic                cnt_term_in,
  output logic                busy
);

  state_e            state;
  logic [DATA_W-1:0] value_q;
  logic              dir_q;
  logic [CYC_W-1:0]  cyc;
  logic              first_run;
  logic              at_limit;
  logic              load_err;

  assign at_limit = (cyc == CYC_W'(TIMEOUT));

`ifdef CNT_CTRL_LOAD_CHECK_EN
  // The counter must show the preload value on the first RUN cycle, otherwise the load was lost.
  assign load_err = first_run && (cnt_count_in != value_q);
`else
  logic unused_inputs;
  assign unused_inputs = ^{cnt_count_in, first_run};
  assign load_err      = 1'b0;
`endif

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign cnt_load    = (state == LOAD);
  assign cnt_data    = value_q;
  assign cnt_up_down = dir_q;
  assign cnt_enable  = (state == LOAD) ||
                       ((state == RUN) && !cnt_term_in && !cmd_abort && !at_limit && !load_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      value_q    <= '0;
      dir_q      <= 1'b0;
      cyc        <= '0;
      first_run  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            value_q <= cmd_value;
            dir_q   <= cmd_dir;
            cyc     <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (cmd_abort) begin
            rsp_status <= ST_ABORT;
            rsp_cycles <= '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            first_run <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          first_run <= 1'b0;
          // Exit priority mirrors the cnt_enable terms; the final branch is the enabled cycle.
          if (load_err) begin
            rsp_status <= ST_LOAD_ERR;
            rsp_cycles <= '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (cnt_term_in) begin
            rsp_status <= ST_OK;
            rsp_cycles <= cyc;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (cmd_abort) begin
            rsp_status <= ST_ABORT;
            rsp_cycles <= cyc;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (at_limit) begin
            rsp_status <= ST_TIMEOUT;
            rsp_cycles <= cyc;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl driving a behavioural 8-bit up/down counter.
module tb_counter_ctrl;
  import cnt_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        cmd_valid, cmd_ready, cmd_dir, cmd_abort;
  logic [7:0]  cmd_value;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [15:0] rsp_cycles;
  logic        cnt_load, cnt_enable, cnt_up_down, busy;
  logic [7:0]  cnt_data, count_a;
  logic        term_a;

  logic        cmd_valid_t, cmd_ready_t, cmd_dir_t, cmd_abort_t;
  logic [7:0]  cmd_value_t;
  logic        rsp_valid_t, rsp_ready_t;
  logic [1:0]  rsp_status_t;
  logic [15:0] rsp_cycles_t;
  logic        cnt_load_t, cnt_enable_t, cnt_up_down_t, busy_t;
  logic [7:0]  cnt_data_t, count_t;
  logic        term_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_value(cmd_value),
    .cmd_dir(cmd_dir), .cmd_abort(cmd_abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_cycles(rsp_cycles),
    .cnt_load(cnt_load), .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down),
    .cnt_data(cnt_data), .cnt_count_in(count_a), .cnt_term_in(term_a),
    .busy(busy)
  );

  counter_ctrl #(.TIMEOUT(10)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid_t), .cmd_ready(cmd_ready_t), .cmd_value(cmd_value_t),
    .cmd_dir(cmd_dir_t), .cmd_abort(cmd_abort_t),
    .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_status(rsp_status_t),
    .rsp_cycles(rsp_cycles_t),
    .cnt_load(cnt_load_t), .cnt_enable(cnt_enable_t), .cnt_up_down(cnt_up_down_t),
    .cnt_data(cnt_data_t), .cnt_count_in(count_t), .cnt_term_in(term_t),
    .busy(busy_t)
  );

  // Counter model: load needs enable; terminal count flags a zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_a <= '0;
    else if (cnt_enable) begin
      if (cnt_load)         count_a <= cnt_data;
      else if (cnt_up_down) count_a <= count_a + 8'd1;
      else                  count_a <= count_a - 8'd1;
    end
  end
  assign term_a = (count_a == 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_t <= '0;
    else if (cnt_enable_t) begin
      if (cnt_load_t)         count_t <= cnt_data_t;
      else if (cnt_up_down_t) count_t <= count_t + 8'd1;
      else                    count_t <= count_t - 8'd1;
    end
  end
  assign term_t = (count_t == 8'd0);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one command, watches LOAD, then counts enabled RUN cycles until rsp_valid.
  task automatic applyStimulus(input logic [7:0] v, input logic d, input int abort_at,
                               output int en_cnt, output int loads, output int lat);
    en_cnt = 0;
    loads  = 0;
    lat    = -1;
    @(negedge clk);
    cmd_value = v;
    cmd_dir   = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_value = ~v;
    cmd_dir   = ~d;
    #1;
    checkOutput("load_pulse", {31'd0, cnt_load}, 32'd1);
    checkOutput("load_enable", {31'd0, cnt_enable}, 32'd1);
    checkOutput("load_data", {24'd0, cnt_data}, {24'd0, v});
    checkOutput("load_ready_low", {31'd0, cmd_ready}, 32'd0);
    loads = 1;
    for (int k = 1; k <= 1500; k++) begin
      @(negedge clk);
      if (k == abort_at) cmd_abort = 1'b1;
      #1;
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (cnt_load) loads++;
      if (cnt_enable) en_cnt++;
    end
    cmd_abort = 1'b0;
    checkOutput("rsp_arrived", {31'd0, (lat > 0)}, 32'd1);
  endtask

  task automatic finishResp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    checkOutput("idle_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int en_cnt, loads, lat;
    bit seen;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_value = '0; cmd_dir = 1'b0; cmd_abort = 1'b0; rsp_ready = 1'b0;
    cmd_valid_t = 1'b0; cmd_value_t = '0; cmd_dir_t = 1'b0; cmd_abort_t = 1'b0; rsp_ready_t = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_status", {30'd0, rsp_status}, 32'd0);
    checkOutput("rst_cycles", {16'd0, rsp_cycles}, 32'd0);
    checkOutput("rst_cnt_out", {22'd0, cnt_load, cnt_enable, cnt_up_down, cnt_data}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rst_n = 1'b1;

    $display("[TB] down from 5");
    applyStimulus(8'd5, 1'b0, 0, en_cnt, loads, lat);
    checkOutput("d5_enabled", en_cnt, 32'd5);
    checkOutput("d5_loads", loads, 32'd1);
    checkOutput("d5_status", {30'd0, rsp_status}, ST_OK);
    checkOutput("d5_cycles", {16'd0, rsp_cycles}, 32'd5);
    checkOutput("d5_count", {24'd0, count_a}, 32'd0);
    finishResp();

    $display("[TB] up from 200");
    applyStimulus(8'd200, 1'b1, 0, en_cnt, loads, lat);
    checkOutput("u200_enabled", en_cnt, 32'd56);
    checkOutput("u200_status", {30'd0, rsp_status}, ST_OK);
    checkOutput("u200_cycles", {16'd0, rsp_cycles}, 32'd56);
    checkOutput("u200_count", {24'd0, count_a}, 32'd0);
    finishResp();

    $display("[TB] up from 0");
    applyStimulus(8'd0, 1'b1, 0, en_cnt, loads, lat);
    checkOutput("u0_enabled", en_cnt, 32'd0);
    checkOutput("u0_latency", lat, 32'd2);
    checkOutput("u0_status", {30'd0, rsp_status}, ST_OK);
    checkOutput("u0_cycles", {16'd0, rsp_cycles}, 32'd0);
    finishResp();

    $display("[TB] timeout instance, down from 100");
    @(negedge clk);
    cmd_value_t = 8'd100;
    cmd_dir_t   = 1'b0;
    cmd_valid_t = 1'b1;
    @(negedge clk);
    cmd_valid_t = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid_t) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("to_arrived", {31'd0, seen}, 32'd1);
    checkOutput("to_status", {30'd0, rsp_status_t}, ST_TIMEOUT);
    checkOutput("to_cycles", {16'd0, rsp_cycles_t}, 32'd10);
    checkOutput("to_count", {24'd0, count_t}, 32'd90);
    rsp_ready_t = 1'b1;
    @(negedge clk);
    rsp_ready_t = 1'b0;
    #1;
    checkOutput("to_drop", {31'd0, rsp_valid_t}, 32'd0);

    $display("[TB] abort on RUN cycle 4");
    applyStimulus(8'd50, 1'b0, 4, en_cnt, loads, lat);
    checkOutput("ab_enabled", en_cnt, 32'd3);
    checkOutput("ab_status", {30'd0, rsp_status}, ST_ABORT);
    checkOutput("ab_cycles", {16'd0, rsp_cycles}, 32'd3);
    checkOutput("ab_count", {24'd0, count_a}, 32'd47);
    finishResp();

    $display("[TB] back-pressure");
    applyStimulus(8'd3, 1'b0, 0, en_cnt, loads, lat);
    cmd_value = 8'd9;
    cmd_dir   = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_valid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("bp_status", {30'd0, rsp_status}, ST_OK);
      checkOutput("bp_cycles", {16'd0, rsp_cycles}, 32'd3);
      checkOutput("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp_drop", {31'd0, rsp_valid}, 32'd0);
    checkOutput("bp_not_taken", {31'd0, cnt_load}, 32'd0);
    checkOutput("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checkOutput("bp_new_load", {31'd0, cnt_load}, 32'd1);
    checkOutput("bp_new_data", {24'd0, cnt_data}, 32'd9);

    $display("[TB] reset mid-RUN");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("mr_running", {31'd0, cnt_enable}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_busy", {31'd0, busy}, 32'd0);
    checkOutput("mr_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("mr_cnt_out", {22'd0, cnt_load, cnt_enable, cnt_up_down, cnt_data}, 32'd0);
    checkOutput("mr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("mr_no_rsp", {31'd0, seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
